apb_requester: RTL and testbench

- APB requester (bridge) that sits directly upstream of the team's 32x32-bit APB register-file completer.
- Accepts single read/write commands on a valid/ready command port and runs the APB SETUP/ACCESS sequence on the bus.
- Returns the read data, or a timeout error, on a valid/ready response port.
- Handles completers that insert wait states by holding ACCESS until pready, bounded by a timeout counter.

---
 rtl/apb_requester.sv | 123 ++++++++++++
 tb/tb_apb_requester.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_requester.sv
// apb_requester: single-outstanding APB requester.
// Takes one read/write command on a valid/ready port and runs the APB
// SETUP/ACCESS sequence on the bus. The read data, or a timeout error,
// comes back on a valid/ready response port.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | bus idle, cmd_ready=1, waiting for cmd_valid
// SETUP  | psel=1, penable=0 for exactly one cycle
// ACCESS | psel=penable=1, waiting for pready or a timeout abort
// RESP   | bus idle, response held until rsp_ready
module apb_requester #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic              pclk,
    input  logic              prst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Value the wait counter holds in the last ACCESS cycle before an
    // abort. It is only used when TIMEOUT is non-zero.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam bit               TO_EN    = (TIMEOUT != 0);

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;

    // Commands are accepted only in IDLE, which keeps one command outstanding.
    assign cmd_ready = (state == ST_IDLE);

    // Sequencer: APB phases, wait-state timeout and response holding.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        pwrite  <= cmd_write;
                        paddr   <= cmd_addr;
                        pwdata  <= cmd_wdata;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        state   <= ST_SETUP;
                    end else begin
                        psel    <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // pready is checked before the timeout, so a completion
                    // in the final allowed cycle still counts as a success.
                    if (pready) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_rdata <= pwrite ? '0 : prdata;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else if (TO_EN && (wait_cnt == CNT_LAST)) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        wait_cnt  <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: directed bench for apb_requester with TIMEOUT=4.
// The bench plays the APB completer, holding a 32-word memory and a
// programmable number of wait states per transfer. Each command pushes its
// expected response into a queue, and that entry is popped and compared
// when rsp_valid appears.
module tb_apb_requester;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TO = 4;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    logic          pclk;
    logic          prst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready;
    logic [DW-1:0] prdata;

    int            n_assert;
    int            n_fail;
    rsp_t          exp_q[$];
    logic [DW-1:0] model_mem[32];
    logic [DW-1:0] cmem[32];

    apb_requester #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO),
        .CNT_W  (8)
    ) dut (
        .pclk     (pclk),
        .prst_n   (prst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pready   (pready),
        .prdata   (prdata)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one command from an IDLE negedge. The completer raises pready in
    // ACCESS cycle waits+1 (never, if waits >= TO). The response is held
    // under backpressure for 'hold' cycles. The task returns on the negedge
    // where the requester is back in IDLE.
    task automatic run_cmd(input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input int waits, input int hold);
        rsp_t exp;
        rsp_t got;
        int   acc;
        bit   done;
        int   exp_acc;
        chk("cmd_ready_idle", DW'(cmd_ready), DW'(1));
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        if (waits < TO) begin
            exp.err   = 1'b0;
            exp.rdata = wr ? '0 : model_mem[addr];
            if (wr) model_mem[addr] = wd;
            exp_acc = waits + 1;
        end else begin
            exp.err   = 1'b1;
            exp.rdata = '0;
            exp_acc = TO;
        end
        exp_q.push_back(exp);
        @(negedge pclk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = $urandom;
        chk("setup_psel", DW'(psel), DW'(1));
        chk("setup_penable", DW'(penable), DW'(0));
        chk("setup_paddr", DW'(paddr), DW'(addr));
        chk("setup_pwrite", DW'(pwrite), DW'(wr));
        chk("setup_pwdata", pwdata, wd);
        acc  = 0;
        done = 1'b0;
        while (!done && acc < 20) begin
            @(negedge pclk);
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                acc++;
                chk("access_psel", DW'(psel), DW'(1));
                chk("access_penable", DW'(penable), DW'(1));
                chk("access_paddr", DW'(paddr), DW'(addr));
                chk("access_pwdata", pwdata, wd);
                if (acc - 1 == waits) begin
                    pready = 1'b1;
                    if (wr) begin
                        cmem[addr] = wd;
                        prdata = $urandom;
                    end else begin
                        prdata = cmem[addr];
                    end
                end else begin
                    pready = 1'b0;
                    prdata = $urandom;
                end
            end
        end
        pready = 1'b0;
        prdata = $urandom;
        chk("rsp_arrived", DW'(done), DW'(1));
        chk("access_cycles", DW'(acc), DW'(exp_acc));
        chk("resp_psel", DW'(psel), DW'(0));
        chk("resp_penable", DW'(penable), DW'(0));
        got.rdata = rsp_rdata;
        got.err   = rsp_err;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        chk("rsp_rdata", got.rdata, exp.rdata);
        chk("rsp_err", DW'(got.err), DW'(exp.err));
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            cmd_valid = 1'b1;
            @(negedge pclk);
            chk("bp_rsp_valid", DW'(rsp_valid), DW'(1));
            chk("bp_rsp_rdata", rsp_rdata, exp.rdata);
            chk("bp_rsp_err", DW'(rsp_err), DW'(exp.err));
            chk("bp_cmd_ready", DW'(cmd_ready), DW'(0));
            chk("bp_psel", DW'(psel), DW'(0));
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        chk("post_rsp_valid", DW'(rsp_valid), DW'(0));
        chk("post_cmd_ready", DW'(cmd_ready), DW'(1));
        chk("post_psel", DW'(psel), DW'(0));
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        prst_n    = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        prdata    = '0;
        for (int i = 0; i < 32; i++) begin
            model_mem[i] = '0;
            cmem[i]      = '0;
        end

        // Reset state
        repeat (3) @(negedge pclk);
        chk("rst_psel", DW'(psel), DW'(0));
        chk("rst_penable", DW'(penable), DW'(0));
        chk("rst_pwrite", DW'(pwrite), DW'(0));
        chk("rst_paddr", DW'(paddr), DW'(0));
        chk("rst_pwdata", pwdata, DW'(0));
        chk("rst_rsp_valid", DW'(rsp_valid), DW'(0));
        chk("rst_rsp_rdata", rsp_rdata, DW'(0));
        chk("rst_rsp_err", DW'(rsp_err), DW'(0));
        prst_n = 1'b1;
        @(negedge pclk);
        chk("idle_cmd_ready", DW'(cmd_ready), DW'(1));

        // Zero-wait write, then a read with one wait state
        run_cmd(1'b1, 5'd5, 32'hDEADBEEF, 0, 0);
        run_cmd(1'b0, 5'd5, 32'h0, 1, 0);

        // Timeout with pready never raised, then pready in the last allowed cycle
        run_cmd(1'b1, 5'd7, 32'h12345678, 100, 0);
        run_cmd(1'b0, 5'd7, 32'h0, TO - 1, 0);

        // Response backpressure with a pending command
        run_cmd(1'b0, 5'd5, 32'h0, 0, 5);

        // Back-to-back writes then reads across the whole address space
        for (int a = 0; a < 32; a++)
            run_cmd(1'b1, AW'(a), DW'(a * 3), int'($urandom_range(0, 2)), 0);
        for (int a = 0; a < 32; a++)
            run_cmd(1'b0, AW'(a), 32'h0, int'($urandom_range(0, 2)), 0);

        // Reset in the middle of ACCESS
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 5'd3;
        cmd_wdata = 32'hCAFEF00D;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        chk("mid_access_penable", DW'(penable), DW'(1));
        #2 prst_n = 1'b0;
        #1;
        chk("arst_psel", DW'(psel), DW'(0));
        chk("arst_penable", DW'(penable), DW'(0));
        chk("arst_rsp_valid", DW'(rsp_valid), DW'(0));
        @(negedge pclk);
        prst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            chk("post_rst_cmd_ready", DW'(cmd_ready), DW'(1));
            chk("post_rst_rsp_valid", DW'(rsp_valid), DW'(0));
            chk("post_rst_psel", DW'(psel), DW'(0));
        end

        // The aborted write must not have landed, and the bus still works
        run_cmd(1'b0, 5'd3, 32'h0, 0, 0);
        chk("queue_empty", DW'(exp_q.size()), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
